// File: rtl/seq_accum_pkg.sv
// Shared types and constants for the sample-accumulate unit.
package seq_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/seq_accum_unit_dp.sv
// Datapath: sample register A, accumulator B, result register and sat flag,
// plus the saturating-sum / max fold.
module seq_accum_dp
  import seq_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OUT_W = 6
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             a_load_i,
  input  logic             b_load_i,
  input  logic             r_load_i,
  input  logic             mode_i,
  input  logic             sat_run_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             ovf_o,
  output logic [OUT_W-1:0] dout_o,
  output logic             sat_o
);

  logic [OUT_W-1:0] a_q, b_q, dout_q;
  logic             sat_q;
  logic [OUT_W:0]   sum;
  logic [OUT_W-1:0] fold;
  logic             ovf;

  always_comb begin
    sum  = {1'b0, b_q} + {1'b0, a_q};
    ovf  = (mode_i == MODE_SUM) && sum[OUT_W];
    fold = '0;
    if (mode_i == MODE_MAX) begin
      fold = (a_q > b_q) ? a_q : b_q;
    end else begin
      fold = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (a_load_i) a_q <= OUT_W'(din_i);
      if (clr_i) begin
        b_q <= '0;
      end else if (b_load_i) begin
        b_q <= fold;
      end
      if (r_load_i) begin
        dout_q <= fold;
        sat_q  <= sat_run_i | ovf;
      end
    end
  end

  assign ovf_o  = ovf;
  assign dout_o = dout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/seq_accum_unit.sv
// Control unit: start/busy/done sequencing, sample counter and latched mode;
// drives the datapath load strobes.
module seq_accum_unit
  import seq_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int OUT_W = 6
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] DinA,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] DoutB,
  output logic             sat
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic          sat_run_q;
  logic          BClr, ALoad, BLoad, RLoad;
  logic          ovf;
  logic          last;

  assign last = (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (din_valid) state_d = ACC;
      ACC:     state_d = last ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state_q == WAIT);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    BClr      = (state_q == IDLE) && start;
    ALoad     = (state_q == WAIT) && din_valid;
    BLoad     = (state_q == ACC);
    RLoad     = (state_q == ACC) && last;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q     <= '0;
      mode_q    <= MODE_SUM;
      sat_run_q <= 1'b0;
    end else if (BClr) begin
      cnt_q     <= '0;
      mode_q    <= mode;
      sat_run_q <= 1'b0;
    end else if (BLoad) begin
      cnt_q     <= cnt_q + CW'(1);
      sat_run_q <= sat_run_q | ovf;
    end
  end

  seq_accum_dp #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W)
  ) u_dp (
    .clock     (clock),
    .rst       (rst),
    .clr_i     (BClr),
    .a_load_i  (ALoad),
    .b_load_i  (BLoad),
    .r_load_i  (RLoad),
    .mode_i    (mode_q),
    .sat_run_i (sat_run_q),
    .din_i     (DinA),
    .ovf_o     (ovf),
    .dout_o    (DoutB),
    .sat_o     (sat)
  );

endmodule

// File: tb/tb_seq_accum_unit.sv
// Scoreboard bench: two instances (OUT_W=6 and OUT_W=5) share one stimulus stream.
module tb_seq_accum_unit;

  localparam int COUNT = 4;

  logic       clock = 1'b0;
  logic       rst, start, mode, din_valid;
  logic [3:0] DinA;
  logic       rdy6, busy6, done6, sat6;
  logic [5:0] dout6;
  logic       rdy5, busy5, done5, sat5;
  logic [4:0] dout5;

  always #5 clock = ~clock;

  seq_accum_unit #(.WIDTH(4), .COUNT(COUNT), .OUT_W(6)) u_dut6 (
    .clock(clock), .rst(rst), .start(start), .mode(mode), .din_valid(din_valid),
    .DinA(DinA), .din_ready(rdy6), .busy(busy6), .done(done6), .DoutB(dout6), .sat(sat6)
  );

  seq_accum_unit #(.WIDTH(4), .COUNT(COUNT), .OUT_W(5)) u_dut5 (
    .clock(clock), .rst(rst), .start(start), .mode(mode), .din_valid(din_valid),
    .DinA(DinA), .din_ready(rdy5), .busy(busy5), .done(done5), .DoutB(dout5), .sat(sat5)
  );

  typedef struct {
    int unsigned d6;
    int unsigned s6;
    int unsigned d5;
    int unsigned s5;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   runs   = 0;
  int   dones  = 0;
  int   cyc    = 0;
  int   acc_n  = 0;
  int   due    = -1;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a saturating running sum of non-negative samples equals the
  // clipped total, and it saturated iff the total exceeds the ceiling.
  function automatic exp_t model(input int unsigned s[4], input logic m);
    exp_t        e;
    int unsigned tot = 0, mx = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      tot += s[i];
      if (s[i] > mx) mx = s[i];
    end
    if (m) begin
      e.d6 = mx; e.s6 = 0; e.d5 = mx; e.s5 = 0;
    end else begin
      e.d6 = (tot > 63) ? 63 : tot; e.s6 = (tot > 63) ? 1 : 0;
      e.d5 = (tot > 31) ? 31 : tot; e.s5 = (tot > 31) ? 1 : 0;
    end
    return e;
  endfunction

  // Monitor: tracks handshakes, predicts the done cycle, pops the scoreboard on done.
  always @(negedge clock) begin
    cyc++;
    if (rst) begin
      acc_n = 0;
      due   = -1;
    end else begin
      if (done6 || done5) begin
        exp_t e;
        dones++;
        chk("done_pair", {31'd0, done5}, {31'd0, done6});
        chk("done_cycle", cyc, due);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout6", dout6, e.d6);
          chk("sat6", sat6, e.s6);
          chk("dout5", dout5, e.d5);
          chk("sat5", sat5, e.s5);
        end
      end else if (cyc == due) begin
        chk("done_missing", 0, 1);
      end
      if (din_valid && rdy6) begin
        acc_n++;
        if (acc_n == COUNT) begin
          due   = cyc + 2;
          acc_n = 0;
        end
      end
    end
  end

  task automatic run(input int unsigned s[4], input logic m, input int maxgap,
                     input bit disturb, input int abort_after);
    int t;
    @(posedge clock); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clock); #1;
    if (!disturb) start = 1'b0;
    if (abort_after == 0) begin
      exp_q.push_back(model(s, m));
      runs++;
    end
    chk("ready_after_start", {31'd0, rdy6}, 1);
    for (int i = 0; i < 4; i++) begin
      int gap;
      if (abort_after != 0 && i == abort_after) break;
      gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      if (gap > 0) begin
        din_valid = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
      end
      din_valid = 1'b1;
      DinA      = 4'(s[i]);
      if (disturb) mode = ~mode;
      t = 0;
      do begin @(negedge clock); t++; end while (!rdy6 && t < 20);
      if (!rdy6) chk("ready_timeout", 0, 1);
      @(posedge clock); #1;
      if (disturb && i == 3) start = 1'b0;
    end
    if (maxgap > 0) din_valid = 1'b0;
    if (abort_after != 0) begin
      rst = 1'b1;
      @(posedge clock); #1;
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_dout6", dout6, 0);
      chk("abort_dout5", dout5, 0);
      chk("abort_flags", {28'd0, sat6, sat5, busy6, busy5}, 0);
      return;
    end
    t = 0;
    do begin @(negedge clock); t++; end while (!done6 && t < 20);
    if (!done6) chk("done_timeout", 0, 1);
    if (disturb) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; din_valid = 1'b1; DinA = 4'd5;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clock);
      chk("idle_flags", {24'd0, busy6, rdy6, done6, sat6, busy5, rdy5, done5, sat5}, 0);
      chk("idle_dout6", dout6, 0);
      chk("idle_dout5", dout5, 0);
    end

    run('{1, 2, 3, 4}, 1'b0, 0, 1'b0, 0);
    run('{15, 15, 15, 15}, 1'b0, 0, 1'b0, 0);
    run('{1, 1, 1, 1}, 1'b0, 0, 1'b0, 0);
    run('{3, 9, 2, 7}, 1'b1, 3, 1'b0, 0);
    run('{5, 6, 7, 8}, 1'b0, 1, 1'b1, 0);
    run('{3, 9, 2, 7}, 1'b1, 2, 1'b1, 0);
    run('{4, 5, 6, 7}, 1'b0, 0, 1'b0, 2);
    run('{1, 1, 1, 1}, 1'b0, 0, 1'b0, 0);

    for (int r = 0; r < 24; r++) begin
      int unsigned s[4];
      for (int j = 0; j < 4; j++) s[j] = $urandom_range(15, 0);
      run(s, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
          1'($urandom_range(1, 0)), 0);
    end

    repeat (5) @(posedge clock);
    chk("done_count", dones, runs);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
